pipelined_addsub: RTL and testbench

//  Parametrised, pipelined adder/subtractor; successor to the 8-bit combinational ripple adder.

---
 rtl/pipelined_addsub_pkg.sv | 15 +
 rtl/pipelined_addsub_seg.sv | 14 +
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 tb/tb_pipelined_addsub.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // The carry chain must split into equal, non-empty segments.
    function automatic bit split_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_seg.sv
// One SEG-bit combinational slice of the carry chain: s = a + b + ci, co = carry out.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered segments,
// with a global valid/ready stall so backpressure never drops or duplicates a beat.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!split_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Per-stage state: operand A, converted operand B', partial result, carry, valid.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic [WIDTH-1:0] res_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] vld_q, vld_d;

    logic [SEG-1:0]    seg_a [STAGES];
    logic [SEG-1:0]    seg_b [STAGES];
    logic [SEG-1:0]    seg_s [STAGES];
    logic [STAGES-1:0] seg_ci;
    logic [STAGES-1:0] seg_co;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is a + ~b + ~borrow_in; convert once at capture.
    assign b_eff = (sub == MODE_SUB) ? ~b : b;
    assign c0    = (sub == MODE_SUB) ? ~cin : cin;

    assign adv      = !vld_q[LAST] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]  = a[SEG-1:0];
            assign seg_b[k]  = b_eff[SEG-1:0];
            assign seg_ci[k] = c0;
        end else begin : g_next
            assign seg_a[k]  = a_q[k-1][k*SEG +: SEG];
            assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
            assign seg_ci[k] = c_q[k-1];
        end

        addsub_seg #(.SEG(SEG)) u_seg (
            .a  (seg_a[k]),
            .b  (seg_b[k]),
            .ci (seg_ci[k]),
            .s  (seg_s[k]),
            .co (seg_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                a_d[k]   = a;
                b_d[k]   = b_eff;
                res_d[k] = '0;
                vld_d[k] = in_valid;
            end else begin
                a_d[k]   = a_q[(k > 0) ? k - 1 : 0];
                b_d[k]   = b_q[(k > 0) ? k - 1 : 0];
                res_d[k] = res_q[(k > 0) ? k - 1 : 0];
                vld_d[k] = vld_q[(k > 0) ? k - 1 : 0];
            end
            res_d[k][k*SEG +: SEG] = seg_s[k];
            c_d[k]                 = seg_co[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
    end

    // Data path carries no reset; outputs are masked by valid instead.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                res_q[k] <= res_d[k];
            end
            c_q <= c_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign sum       = out_valid ? res_q[LAST] : '0;
    assign cout      = out_valid & c_q[LAST];
    assign ovf       = out_valid
                     & (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                     & (res_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed-vector and scoreboard bench for pipelined_addsub at several widths/depths.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit, 2-stage instance
    logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0] a8, b8, s8;

    // 32-bit instances sharing one input stream: idx 0..2 -> STAGES 1,2,8; idx 3 -> defaults
    logic        iv, or32, cin, sub;
    logic [31:0] a32, b32;
    logic        ir_w [4];
    logic        ov_w [4];
    logic        co_w [4];
    logic        of_w [4];
    logic [31:0] s_w  [4];

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    for (genvar i = 0; i < 3; i++) begin : g_sw
        localparam int ST = (i == 0) ? 1 : ((i == 1) ? 2 : 8);
        pipelined_addsub #(.WIDTH(32), .STAGES(ST)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_w[i]), .a(a32), .b(b32),
            .cin(cin), .sub(sub), .out_valid(ov_w[i]), .out_ready(or32), .sum(s_w[i]),
            .cout(co_w[i]), .ovf(of_w[i])
        );
    end

    pipelined_addsub u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_w[3]), .a(a32), .b(b32),
        .cin(cin), .sub(sub), .out_valid(ov_w[3]), .out_ready(or32), .sum(s_w[3]),
        .cout(co_w[3]), .ovf(of_w[3])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       of;
    } vec_t;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        of;
    } res_t;

    res_t q [4][$];

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [31:0] yy;
        logic        c0;
        logic [32:0] f;
        yy   = sb ? ~y : y;
        c0   = sb ? ~ci : ci;
        f    = {1'b0, x} + {1'b0, yy} + {32'd0, c0};
        r.s  = f[31:0];
        r.co = f[32];
        r.of = (x[31] == yy[31]) && (f[31] != x[31]);
        return r;
    endfunction

    task automatic cmp_out(input int i, input string tag);
        res_t e;
        if (q[i].size() == 0) begin
            chk($sformatf("%s_spurious_%0d", tag, i), 64'(ov_w[i]), 64'd0);
        end else begin
            e = q[i][0];
            chk($sformatf("%s_sum_%0d", tag, i), 64'(s_w[i]), 64'(e.s));
            chk($sformatf("%s_cout_%0d", tag, i), 64'(co_w[i]), 64'(e.co));
            chk($sformatf("%s_ovf_%0d", tag, i), 64'(of_w[i]), 64'(e.of));
        end
    endtask

    vec_t vt [10];

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, got, found;
        res_t e;

        vt[0] = '{8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[3] = '{8'h05, 8'h0A, 1'b0, 1'b1, 8'hFB, 1'b0, 1'b0};
        vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[5] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[6] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        iv  = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid8", 64'(ov8), 64'd0);
        chk("rst_sum8", 64'(s8), 64'd0);
        chk("rst_cout8", 64'(co8), 64'd0);
        chk("rst_ovf8", 64'(of8), 64'd0);
        chk("rst_in_ready8", 64'(ir8), 64'd1);
        chk("rst_out_valid32", 64'(ov_w[3]), 64'd0);
        chk("rst_in_ready32", 64'(ir_w[3]), 64'd1);
        rst_n = 1'b1;

        // Single beats through the 8-bit, 2-stage instance
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            iv8 = 1'b1; a8 = vt[i].a; b8 = vt[i].b; cin8 = vt[i].cin; sub8 = vt[i].sub;
            @(posedge clk);
            #1;
            iv8 = 1'b0;
            chk($sformatf("v%0d_early_valid", i), 64'(ov8), 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(ov8), 64'd1);
            chk($sformatf("v%0d_sum", i), 64'(s8), 64'(vt[i].s));
            chk($sformatf("v%0d_cout", i), 64'(co8), 64'(vt[i].co));
            chk($sformatf("v%0d_ovf", i), 64'(of8), 64'(vt[i].of));
        end

        // Back-to-back beats with out_ready toggling on the default-parameter instance
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(posedge clk);
            #1;
            iv   = (sent < 8);
            a32  = 32'hFFFF_FFF0 + 32'(sent);
            b32  = 32'h1111_1111 * 32'(sent);
            sub  = sent[0];
            cin  = sent[1];
            or32 = (cyc % 2 == 0);
            #1;
            chk($sformatf("bp_in_ready_c%0d", cyc), 64'(ir_w[3]), 64'(!(ov_w[3] && !or32)));
            if (ov_w[3]) begin
                cmp_out(3, "bp");
                if (or32 && q[3].size() != 0) begin
                    void'(q[3].pop_front());
                    got++;
                end
            end
            if (iv && ir_w[3]) begin
                q[3].push_back(model(a32, b32, cin, sub));
                sent++;
            end
        end
        chk("bp_results_retired", 64'(got), 64'd8);
        iv   = 1'b0;
        or32 = 1'b1;

        // Reset with three beats in flight
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            iv = 1'b1; a32 = 32'h100 * 32'(j + 1); b32 = 32'h5; sub = 1'b0; cin = 1'b0;
        end
        @(posedge clk);
        #1;
        iv    = 1'b0;
        found = 0;
        for (int w = 0; w < 10 && found == 0; w++) begin
            if (ov_w[3]) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("rst_mid_first_result_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(ov_w[3]), 64'd0);
        chk("rst_mid_sum", 64'(s_w[3]), 64'd0);
        chk("rst_mid_out_valid_s8", 64'(ov_w[2]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int w = 0; w < 10; w++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                chk($sformatf("rst_no_stale_%0d_%0d", i, w), 64'(ov_w[i]), 64'd0);
        end
        for (int i = 0; i < 4; i++) q[i].delete();

        // Sweep across STAGES = 1, 2, 8 and 4 at WIDTH = 32
        sent = 0;
        for (int n = 0; n < 320; n++) begin
            @(posedge clk);
            #1;
            iv  = (sent < 250) && ((n < 4) || ($urandom_range(0, 7) != 0));
            a32 = $urandom;
            b32 = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            case (n)
                0: begin a32 = 32'hFFFF_FFFF; b32 = 32'h1; cin = 1'b0; sub = 1'b0; end
                1: begin a32 = 32'h7FFF_FFFF; b32 = 32'h1; cin = 1'b0; sub = 1'b0; end
                2: begin a32 = 32'h0;         b32 = 32'h1; cin = 1'b0; sub = 1'b1; end
                3: begin a32 = 32'h8000_0000; b32 = 32'h1; cin = 1'b0; sub = 1'b1; end
                default: ;
            endcase
            #1;
            for (int i = 0; i < 4; i++) begin
                if (ov_w[i]) begin
                    cmp_out(i, "sw");
                    if (q[i].size() != 0) void'(q[i].pop_front());
                end
                if (iv && ir_w[i]) begin
                    e = model(a32, b32, cin, sub);
                    q[i].push_back(e);
                end
            end
            if (iv) sent++;
        end
        iv = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("sw_drained_%0d", i), 64'(q[i].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
